csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode control and status register unit for the RV32 core, replacing the fixed read-mostly CSR block. It provides read/write/set/clear access to the machine CSRs and 64-bit cycle and retired-instruction counters with high-half access. It also performs the CSR side of trap entry and `mret`. It sits beside the execute stage: the decoder supplies the address and operation, and the trap controller supplies trap and return events.

## Interface
- `DATA_WIDTH`, 32: CSR data width; only 32 is supported.
- `COUNTER_WIDTH`, 64: width of `mcycle`/`minstret`, legal range 33..64; bits above `COUNTER_WIDTH` read 0.
- `EXT_M`, 1: sets `misa` bit 12.
- `EXT_C`, 0: sets `misa` bit 2; when 1, relaxes `mepc` alignment.
- `EXT_E`, 0: sets `misa` bit 4; when 0, `misa` bit 8 (I) is set instead.
- `MTVEC_RESET`, 32'h0: reset value of `mtvec`.
- `i_clock` input 1: clock.
- `i_reset` input 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `i_addr` input 12: CSR address.
- `i_op` input 2: 00 read only, 01 write, 10 set bits, 11 clear bits.
- `i_wrData` input 32: operand for the write, set or clear.
- `o_rdData` output 32: old value of the addressed CSR (combinational).
- `o_illegal` output 1: access is illegal (combinational).
- `i_instRet` input 1: one-cycle pulse per retired instruction.
- `i_time` input 64: platform timer value.
- `i_irq` input 3: {external, timer, software} interrupt lines.
- `i_trap` input 1: trap-entry pulse.
- `i_trapCause` input 32: cause for `mcause`; bit 31 set means interrupt.
- `i_trapPC` input 32: PC to save in `mepc`.
- `i_mret` input 1: `mret` pulse.
- `o_trapVector` output 32: trap target PC (combinational).
- `o_mepc` output 32: current `mepc`.
- `o_irqPending` output 1: an enabled interrupt is pending and `mstatus.MIE` is 1.

## Operation
- **Read-only CSRs**
  - `misa` (0x301) is a constant: bits 31:30 = 01, bit 20 (U) = 1, plus the extension bits above.
  - `mip` (0x344) returns bits 11/7/3 = `i_irq`[2]/[1]/[0].
  - `cycle`/`cycleh` (C00/C80) and `instret`/`instreth` (C02/C82) alias the machine counters.
  - `time`/`timeh` (C01/C81) return `i_time`.
- **Read/write CSRs**
  - `mstatus` (0x300): only MIE (bit 3) and MPIE (bit 7) are writable. MPP (bits 12:11) always reads 11. All other bits read 0.
  - `mie` (0x304): only bits 11, 7 and 3 are writable; all other bits read 0.
  - `mtvec` (0x305): a written MODE of 2 or 3 is legalised to 00.
  - `mscratch` (0x340) is fully writable.
  - `mepc` (0x341): bit 0 is forced to 0; bit 1 is also forced to 0 when `EXT_C`=0.
  - `mcause` (0x342) is fully writable.
  - `mcycle` (B00), `mcycleh` (B80), `minstret` (B02), `minstreth` (B82) are writable.
- **Write value** applied at the next edge:
  - op 01: `i_wrData`.
  - op 10: old | `i_wrData`.
  - op 11: old & ~`i_wrData`.
  - Legalisation is applied after this computation.
- **Illegal access:** `o_illegal`=1 for an unimplemented address, or for `i_op`≠00 to a read-only CSR. Unimplemented addresses give `o_rdData`=0. An illegal access has no state change.
- **Counters**
  - `mcycle` increments every cycle; `minstret` increments when `i_instRet`=1.
  - Both wrap from all-ones to 0 within `COUNTER_WIDTH`.
  - A CSR write to either half replaces that half, and suppresses the increment that cycle for the whole counter.
- **Trap entry** on `i_trap`:
  - `mepc` ← `i_trapPC`, legalised.
  - `mcause` ← `i_trapCause`.
  - MPIE ← MIE, then MIE ← 0.
- **Return** on `i_mret`: MIE ← MPIE, MPIE ← 1.
- **Simultaneous events**
  - `i_trap` beats `i_mret`.
  - `i_trap` or `i_mret` beats a same-cycle CSR write to `mstatus`, `mepc` or `mcause`; that write is dropped and `o_illegal` is unaffected.
- **Trap vector:** `o_trapVector` = {`mtvec`[31:2], 00}. In vectored mode (MODE 01) with `mcause`[31]=1, it is base + 4·`mcause`[4:0].
- **Interrupt pending:** `o_irqPending` = MIE & |(`mie` & `mip`).

## Timing
- **Reset values:**
  - `mstatus` = 0x0000_1800.
  - `mie`, `mscratch`, `mepc`, `mcause` = 0.
  - `mtvec` = `MTVEC_RESET`.
  - Counters = 0.
  - `o_irqPending` = 0; `o_mepc` = 0.
- Reset is asserted asynchronously and released synchronously to `i_clock`. Reset asserted mid-operation discards any pending write or trap.
- **Reads:** zero latency; `o_rdData` reflects the state before the current edge.
- **Writes, trap and return:** take effect at the next rising edge and are visible the following cycle. A read-after-write in back-to-back cycles returns the new value.
- **Cycle counter:** the first cycle after reset release reads `mcycle`=0. A value written at edge N reads back as that value in cycle N+1, then increments.
- **Low-half carry:** a carry from the low half propagates into the high half in the same edge.
- **Interrupt path:** `o_irqPending` is combinational from registered state plus `i_irq`.

## Test plan
- **Reset:** deassert `i_reset` → `mstatus` reads 0x1800, `misa` reads 0x4010_1100 (defaults), `mcycle` counts 0, 1, 2.
- **Set/clear:** write `mscratch`=0xA5A5_0000, then set 0x0000_00FF, then clear 0xA500_0000 → reads 0x00A5_00FF. Writing `mtvec`=0x8000_0003 reads back 0x8000_0000.
- **Counter wrap:** write `mcycleh`=0xFFFF_FFFF and `mcycle`=0xFFFF_FFFE → reads …FFFF, then `mcycle`=0 and `mcycleh`=0. Same for `minstret` with `i_instRet` pulses.
- **Trap and return:** with MIE=1 and `mtvec`=0x100 | 1, apply `i_trap` with cause 0x8000_0007 and PC 0x2002 (`EXT_C`=0) → `mepc`=0x2000, MIE=0, MPIE=1, `o_trapVector`=0x11C. Then `i_mret` → MIE=1, MPIE=1.
- **Conflicts:** `i_trap` and a write of `mstatus`=0x8 in the same cycle → MIE=0. `i_trap` and `i_mret` together → trap behaviour.
- **Illegal and interrupt:** write to 0xC00 or address 0x7FF → `o_illegal`=1, state unchanged, `o_rdData`=0 for 0x7FF. `mie`=0x80, `i_irq`=010, MIE=1 → `o_irqPending`=1.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: read/write/set/clear access to the machine CSRs,
// 64-bit cycle/instret counters, and the CSR side of trap entry and mret.
module csr_unit #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          COUNTER_WIDTH = 64,
    parameter bit          EXT_M         = 1'b1,
    parameter bit          EXT_C         = 1'b0,
    parameter bit          EXT_E         = 1'b0,
    parameter logic [31:0] MTVEC_RESET   = 32'h0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [11:0]           i_addr,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    output logic [DATA_WIDTH-1:0] o_rdData,
    output logic                  o_illegal,
    input  logic                  i_instRet,
    input  logic [63:0]           i_time,
    input  logic [2:0]            i_irq,
    input  logic                  i_trap,
    input  logic [DATA_WIDTH-1:0] i_trapCause,
    input  logic [DATA_WIDTH-1:0] i_trapPC,
    input  logic                  i_mret,
    output logic [DATA_WIDTH-1:0] o_trapVector,
    output logic [DATA_WIDTH-1:0] o_mepc,
    output logic                  o_irqPending
);
    localparam int CW = COUNTER_WIDTH;
    localparam logic [31:0] MISA = 32'h4010_0000
                                 | (EXT_M ? 32'h0000_1000 : 32'h0)
                                 | (EXT_C ? 32'h0000_0004 : 32'h0)
                                 | (EXT_E ? 32'h0000_0010 : 32'h0000_0100);
    localparam logic [31:0] MEPC_MASK = EXT_C ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    logic          mstatus_mie_q, mstatus_mie_d;
    logic          mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]    mie_en_q, mie_en_d;
    logic [31:0]   mtvec_q, mtvec_d;
    logic [31:0]   mscratch_q, mscratch_d;
    logic [31:0]   mepc_q, mepc_d;
    logic [31:0]   mcause_q, mcause_d;
    logic [CW-1:0] mcycle_q, mcycle_d;
    logic [CW-1:0] minstret_q, minstret_d;

    logic [63:0] mcycle_ext, minstret_ext;
    logic [31:0] rd_data, wr_val, tvec_base;
    logic        hit, read_only, we, wr_blocked, we_eff;

    assign mcycle_ext   = 64'(mcycle_q);
    assign minstret_ext = 64'(minstret_q);

    always_comb begin
        rd_data   = 32'h0;
        hit       = 1'b1;
        read_only = 1'b0;
        case (i_addr)
            12'h300: rd_data = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            12'h301: begin rd_data = MISA; read_only = 1'b1; end
            12'h304: rd_data = {20'b0, mie_en_q[2], 3'b0, mie_en_q[1], 3'b0, mie_en_q[0], 3'b0};
            12'h305: rd_data = mtvec_q;
            12'h340: rd_data = mscratch_q;
            12'h341: rd_data = mepc_q;
            12'h342: rd_data = mcause_q;
            12'h344: begin
                rd_data   = {20'b0, i_irq[2], 3'b0, i_irq[1], 3'b0, i_irq[0], 3'b0};
                read_only = 1'b1;
            end
            12'hB00: rd_data = mcycle_ext[31:0];
            12'hB80: rd_data = mcycle_ext[63:32];
            12'hB02: rd_data = minstret_ext[31:0];
            12'hB82: rd_data = minstret_ext[63:32];
            12'hC00: begin rd_data = mcycle_ext[31:0];    read_only = 1'b1; end
            12'hC80: begin rd_data = mcycle_ext[63:32];   read_only = 1'b1; end
            12'hC02: begin rd_data = minstret_ext[31:0];  read_only = 1'b1; end
            12'hC82: begin rd_data = minstret_ext[63:32]; read_only = 1'b1; end
            12'hC01: begin rd_data = i_time[31:0];        read_only = 1'b1; end
            12'hC81: begin rd_data = i_time[63:32];       read_only = 1'b1; end
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        case (i_op)
            2'b01:   wr_val = i_wrData;
            2'b10:   wr_val = rd_data | i_wrData;
            2'b11:   wr_val = rd_data & ~i_wrData;
            default: wr_val = rd_data;
        endcase
    end

    assign we         = hit && !read_only && (i_op != 2'b00);
    // Trap/mret own mstatus, mepc and mcause this cycle; a racing write is simply lost.
    assign wr_blocked = (i_trap || i_mret) &&
                        (i_addr == 12'h300 || i_addr == 12'h341 || i_addr == 12'h342);
    assign we_eff     = we && !wr_blocked;

    assign o_rdData  = rd_data;
    assign o_illegal = !hit || (read_only && (i_op != 2'b00));

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_en_d       = mie_en_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + CW'(1);
        minstret_d     = i_instRet ? minstret_q + CW'(1) : minstret_q;
        if (we_eff) begin
            case (i_addr)
                12'h300: begin
                    mstatus_mie_d  = wr_val[3];
                    mstatus_mpie_d = wr_val[7];
                end
                12'h304: mie_en_d   = {wr_val[11], wr_val[7], wr_val[3]};
                12'h305: mtvec_d    = {wr_val[31:2], wr_val[1] ? 2'b00 : wr_val[1:0]};
                12'h340: mscratch_d = wr_val;
                12'h341: mepc_d     = wr_val & MEPC_MASK;
                12'h342: mcause_d   = wr_val;
                // Writing either half replaces it and cancels this cycle's increment.
                12'hB00: mcycle_d   = CW'({mcycle_ext[63:32], wr_val});
                12'hB80: mcycle_d   = CW'({wr_val, mcycle_ext[31:0]});
                12'hB02: minstret_d = CW'({minstret_ext[63:32], wr_val});
                12'hB82: minstret_d = CW'({wr_val, minstret_ext[31:0]});
                default: ;
            endcase
        end
        if (i_trap) begin
            mepc_d         = i_trapPC & MEPC_MASK;
            mcause_d       = i_trapCause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (i_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_en_q       <= 3'b0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_en_q       <= mie_en_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    assign tvec_base    = {mtvec_q[31:2], 2'b00};
    assign o_trapVector = (mtvec_q[1:0] == 2'b01 && mcause_q[31])
                        ? tvec_base + {25'b0, mcause_q[4:0], 2'b00} : tvec_base;
    assign o_mepc       = mepc_q;
    assign o_irqPending = mstatus_mie_q & |(mie_en_q & i_irq);
endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit: inputs change on the falling edge, outputs
// are checked 1 time unit later, state updates on the rising edge in between.
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        i_reset;
    logic [11:0] i_addr;
    logic [1:0]  i_op;
    logic [31:0] i_wrData;
    logic [31:0] o_rdData;
    logic        o_illegal;
    logic        i_instRet;
    logic [63:0] i_time;
    logic [2:0]  i_irq;
    logic        i_trap;
    logic [31:0] i_trapCause;
    logic [31:0] i_trapPC;
    logic        i_mret;
    logic [31:0] o_trapVector;
    logic [31:0] o_mepc;
    logic        o_irqPending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_unit dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_addr      (i_addr),
        .i_op        (i_op),
        .i_wrData    (i_wrData),
        .o_rdData    (o_rdData),
        .o_illegal   (o_illegal),
        .i_instRet   (i_instRet),
        .i_time      (i_time),
        .i_irq       (i_irq),
        .i_trap      (i_trap),
        .i_trapCause (i_trapCause),
        .i_trapPC    (i_trapPC),
        .i_mret      (i_mret),
        .o_trapVector(o_trapVector),
        .o_mepc      (o_mepc),
        .o_irqPending(o_irqPending)
    );

    // One access per cycle: held from a falling edge across one rising edge.
    task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                         input logic ir = 1'b0, input logic tr = 1'b0, input logic mr = 1'b0);
        @(negedge clk);
        i_addr = a; i_op = op; i_wrData = d; i_instRet = ir; i_trap = tr; i_mret = mr;
        #1;
        $display("txn addr=%h op=%0d wr=%h ir=%0b trap=%0b mret=%0b -> rd=%h ill=%0b",
                 a, op, d, ir, tr, mr, o_rdData, o_illegal);
    endtask

    task automatic test_reset();
        total++; if (o_mepc !== 32'h0) begin bad++; $display("FAIL rst_mepc got=%h exp=%h", o_mepc, 32'h0); end
        total++; if (o_irqPending !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", o_irqPending); end
        @(negedge clk);
        i_reset = 1'b1; i_addr = 12'hB00; i_op = 2'b00;
        #1;
        total++; if (o_rdData !== 32'd0) begin bad++; $display("FAIL mcycle0 got=%h exp=0", o_rdData); end
        drive(12'hB00, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'd1) begin bad++; $display("FAIL mcycle1 got=%h exp=1", o_rdData); end
        drive(12'hB00, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'd2) begin bad++; $display("FAIL mcycle2 got=%h exp=2", o_rdData); end
        drive(12'h300, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h0000_1800) begin bad++; $display("FAIL rst_mstatus got=%h exp=%h", o_rdData, 32'h1800); end
        drive(12'h301, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h4010_1100) begin bad++; $display("FAIL misa got=%h exp=%h", o_rdData, 32'h4010_1100); end
        total++; if (o_illegal !== 1'b0) begin bad++; $display("FAIL misa_read_illegal got=%b exp=0", o_illegal); end
        drive(12'h305, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL rst_mtvec got=%h exp=0", o_rdData); end
    endtask

    task automatic test_set_clear();
        drive(12'h340, 2'b01, 32'hA5A5_0000);
        drive(12'h340, 2'b10, 32'h0000_00FF);
        total++; if (o_rdData !== 32'hA5A5_0000) begin bad++; $display("FAIL sc_write got=%h exp=%h", o_rdData, 32'hA5A5_0000); end
        drive(12'h340, 2'b11, 32'hA500_0000);
        total++; if (o_rdData !== 32'hA5A5_00FF) begin bad++; $display("FAIL sc_set got=%h exp=%h", o_rdData, 32'hA5A5_00FF); end
        drive(12'h340, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h00A5_00FF) begin bad++; $display("FAIL sc_clear got=%h exp=%h", o_rdData, 32'h00A5_00FF); end
        drive(12'h305, 2'b01, 32'h8000_0003);
        drive(12'h305, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h8000_0000) begin bad++; $display("FAIL mtvec_legal got=%h exp=%h", o_rdData, 32'h8000_0000); end
    endtask

    task automatic test_counter_wrap();
        drive(12'hB80, 2'b01, 32'hFFFF_FFFF);
        drive(12'hB00, 2'b01, 32'hFFFF_FFFE);
        drive(12'hB00, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cyc_written got=%h exp=%h", o_rdData, 32'hFFFF_FFFE); end
        drive(12'hB80, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc_hi_before got=%h exp=%h", o_rdData, 32'hFFFF_FFFF); end
        drive(12'hB00, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL cyc_lo_wrap got=%h exp=0", o_rdData); end
        drive(12'hC80, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL cyc_hi_wrap got=%h exp=0", o_rdData); end
        drive(12'hB82, 2'b01, 32'hFFFF_FFFF);
        drive(12'hB02, 2'b01, 32'hFFFF_FFFE);
        drive(12'hB02, 2'b00, 32'h0, 1'b1);
        total++; if (o_rdData !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ret_written got=%h exp=%h", o_rdData, 32'hFFFF_FFFE); end
        drive(12'hB82, 2'b00, 32'h0, 1'b1);
        total++; if (o_rdData !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ret_hi_before got=%h exp=%h", o_rdData, 32'hFFFF_FFFF); end
        drive(12'hB02, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL ret_lo_wrap got=%h exp=0", o_rdData); end
        drive(12'hC82, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL ret_hi_wrap got=%h exp=0", o_rdData); end
        drive(12'hC02, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL ret_idle got=%h exp=0", o_rdData); end
    endtask

    task automatic test_trap_return();
        drive(12'h300, 2'b01, 32'h8);
        drive(12'h305, 2'b01, 32'h101);
        i_trapCause = 32'h8000_0007; i_trapPC = 32'h2002;
        drive(12'h300, 2'b00, 32'h0, 1'b0, 1'b1);
        total++; if (o_rdData !== 32'h1808) begin bad++; $display("FAIL pre_trap_mstatus got=%h exp=%h", o_rdData, 32'h1808); end
        drive(12'h300, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h1880) begin bad++; $display("FAIL trap_mstatus got=%h exp=%h", o_rdData, 32'h1880); end
        total++; if (o_mepc !== 32'h2000) begin bad++; $display("FAIL trap_mepc got=%h exp=%h", o_mepc, 32'h2000); end
        total++; if (o_trapVector !== 32'h11C) begin bad++; $display("FAIL trap_vector got=%h exp=%h", o_trapVector, 32'h11C); end
        drive(12'h342, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h8000_0007) begin bad++; $display("FAIL trap_mcause got=%h exp=%h", o_rdData, 32'h8000_0007); end
        drive(12'h300, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(12'h300, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=%h", o_rdData, 32'h1888); end
        drive(12'h342, 2'b01, 32'h3);
        drive(12'h342, 2'b00, 32'h0);
        total++; if (o_trapVector !== 32'h100) begin bad++; $display("FAIL exc_vector got=%h exp=%h", o_trapVector, 32'h100); end
    endtask

    task automatic test_conflicts();
        drive(12'h300, 2'b01, 32'h8, 1'b0, 1'b1);
        total++; if (o_illegal !== 1'b0) begin bad++; $display("FAIL conflict_illegal got=%b exp=0", o_illegal); end
        drive(12'h300, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h1880) begin bad++; $display("FAIL trap_vs_write got=%h exp=%h", o_rdData, 32'h1880); end
        drive(12'h300, 2'b01, 32'h80);
        i_trapCause = 32'h5; i_trapPC = 32'h3006;
        drive(12'h300, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1);
        drive(12'h300, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h1800) begin bad++; $display("FAIL trap_vs_mret got=%h exp=%h", o_rdData, 32'h1800); end
        drive(12'h341, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h3004) begin bad++; $display("FAIL trap_vs_mret_mepc got=%h exp=%h", o_rdData, 32'h3004); end
        drive(12'h341, 2'b01, 32'h4444, 1'b0, 1'b0, 1'b1);
        drive(12'h341, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h3004) begin bad++; $display("FAIL mret_vs_mepc_write got=%h exp=%h", o_rdData, 32'h3004); end
        drive(12'h342, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h5) begin bad++; $display("FAIL conflict_mcause got=%h exp=%h", o_rdData, 32'h5); end
    endtask

    task automatic test_illegal_irq();
        drive(12'h301, 2'b01, 32'hFFFF_FFFF);
        total++; if (o_illegal !== 1'b1) begin bad++; $display("FAIL misa_write_illegal got=%b exp=1", o_illegal); end
        drive(12'h301, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h4010_1100) begin bad++; $display("FAIL misa_unchanged got=%h exp=%h", o_rdData, 32'h4010_1100); end
        drive(12'h7FF, 2'b01, 32'h1234);
        total++; if (o_illegal !== 1'b1) begin bad++; $display("FAIL unimpl_illegal got=%b exp=1", o_illegal); end
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL unimpl_rd got=%h exp=0", o_rdData); end
        drive(12'hC00, 2'b10, 32'h1);
        total++; if (o_illegal !== 1'b1) begin bad++; $display("FAIL cycle_write_illegal got=%b exp=1", o_illegal); end
        drive(12'hC81, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h1122_3344) begin bad++; $display("FAIL timeh got=%h exp=%h", o_rdData, 32'h1122_3344); end
        drive(12'h340, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h00A5_00FF) begin bad++; $display("FAIL mscratch_kept got=%h exp=%h", o_rdData, 32'h00A5_00FF); end
        drive(12'h304, 2'b01, 32'hFFFF_FFFF);
        drive(12'h304, 2'b01, 32'h80);
        total++; if (o_rdData !== 32'h888) begin bad++; $display("FAIL mie_mask got=%h exp=%h", o_rdData, 32'h888); end
        drive(12'h300, 2'b01, 32'h8);
        i_irq = 3'b010;
        drive(12'h344, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h80) begin bad++; $display("FAIL mip got=%h exp=%h", o_rdData, 32'h80); end
        total++; if (o_irqPending !== 1'b1) begin bad++; $display("FAIL irq_pending got=%b exp=1", o_irqPending); end
        i_irq = 3'b001;
        drive(12'h344, 2'b00, 32'h0);
        total++; if (o_irqPending !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", o_irqPending); end
        i_irq = 3'b010;
        drive(12'h300, 2'b01, 32'h0);
        drive(12'h300, 2'b00, 32'h0);
        total++; if (o_irqPending !== 1'b0) begin bad++; $display("FAIL irq_mie_off got=%b exp=0", o_irqPending); end
    endtask

    task automatic test_reset_midop();
        i_trapCause = 32'h9; i_trapPC = 32'h5000;
        drive(12'h340, 2'b01, 32'hDEAD_BEEF, 1'b0, 1'b1);
        i_reset = 1'b0;
        #2;
        total++; if (o_mepc !== 32'h0) begin bad++; $display("FAIL async_reset_mepc got=%h exp=0", o_mepc); end
        @(negedge clk);
        i_reset = 1'b1; i_op = 2'b00; i_trap = 1'b0; i_addr = 12'h340;
        #1;
        total++; if (o_rdData !== 32'h0) begin bad++; $display("FAIL midop_mscratch got=%h exp=0", o_rdData); end
        drive(12'h300, 2'b00, 32'h0);
        total++; if (o_rdData !== 32'h1800) begin bad++; $display("FAIL midop_mstatus got=%h exp=%h", o_rdData, 32'h1800); end
    endtask

    initial begin
        i_reset = 1'b0; i_addr = 12'h0; i_op = 2'b00; i_wrData = 32'h0; i_instRet = 1'b0;
        i_time = 64'h1122_3344_5566_7788; i_irq = 3'b000; i_trap = 1'b0;
        i_trapCause = 32'h0; i_trapPC = 32'h0; i_mret = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_set_clear();
        test_counter_wrap();
        test_trap_return();
        test_conflicts();
        test_illegal_irq();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
